// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the M-extension divide sequencer: op codes (also used by
// the ALU control decode), FSM state encoding and the default datapath width.
package div_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] OP_DIV  = 6'b010100;
  localparam logic [5:0] OP_DIVU = 6'b010101;
  localparam logic [5:0] OP_REM  = 6'b010110;
  localparam logic [5:0] OP_REMU = 6'b010111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit 0 of a divide op code selects unsigned, bit 1 selects remainder.
  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
import div_sequencer_pkg::*;

interface div_sequencer_if #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Handshake: start is a request sampled only while busy is low (IDLE or DONE);
  // a requester that sees busy high must keep start asserted until busy drops.
  // done pulses for one cycle with result valid; result then holds until the
  // next done. flush aborts any in-flight op and overrides a coincident start.
  logic             start;
  logic [5:0]       ALUControl;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, ALUControl, operand1, operand2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, ALUControl, operand1, operand2, flush,
    output busy, done, result
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] diff;

  // rem stays below the divisor between steps, so one extra bit of headroom
  // above the shifted partial remainder makes the top bit of diff the borrow.
  always_comb begin
    ext      = {rem, quo[WIDTH-1]};
    diff     = ext - {2'b00, divisor};
    rem_next = ext[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_next    = diff[WIDTH:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: decodes special cases on accept,
// runs one restoring step per cycle, then sign-corrects and selects the result.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  div_sequencer_if.slave bus,
  output state_t         dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] divisor;
  logic             op_rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] result_q;

  logic             op_unsigned;
  logic             op_is_rem;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             div_zero;
  logic             sgn_ovf;
  logic             special;
  logic [WIDTH-1:0] special_result;
  logic             accept;
  logic [WIDTH-1:0] rem_low;
  logic [WIDTH-1:0] fix_result;

  // Request decode, evaluated every cycle but only used on an accepting edge.
  always_comb begin
    op_unsigned = bus.ALUControl[0];
    op_is_rem   = bus.ALUControl[1];
    sign1       = !op_unsigned && bus.operand1[WIDTH-1];
    sign2       = !op_unsigned && bus.operand2[WIDTH-1];
    mag1        = sign1 ? -bus.operand1 : bus.operand1;
    mag2        = sign2 ? -bus.operand2 : bus.operand2;
    div_zero    = (bus.operand2 == '0);
    sgn_ovf     = !op_unsigned
                  && (bus.operand1 == {1'b1, {(WIDTH-1){1'b0}}})
                  && (bus.operand2 == '1);
    special     = div_zero || sgn_ovf;
    if (div_zero) special_result = op_is_rem ? bus.operand1 : '1;
    else          special_result = op_is_rem ? '0 : bus.operand1;
    accept      = ((state == ST_IDLE) || (state == ST_DONE))
                  && bus.start && is_div_op(bus.ALUControl) && !bus.flush;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    rem_low    = rem[WIDTH-1:0];
    fix_result = op_rem ? (neg_r ? -rem_low : rem_low)
                        : (neg_q ? -quo : quo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_CALC;
        ST_CALC: if (count == LAST_STEP) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: begin
          if (accept) state_next = special ? ST_DONE : ST_CALC;
          else        state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A flush freezes the datapath so result keeps its last delivered value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        op_rem  <= op_is_rem;
        neg_q   <= sign1 ^ sign2;
        neg_r   <= sign1;
        divisor <= mag2;
        quo     <= mag1;
        rem     <= '0;
        count   <= '0;
        if (special) result_q <= special_result;
      end else if (state == ST_CALC) begin
        rem   <= rem_next;
        quo   <= quo_next;
        count <= count + 1'b1;
      end else if (state == ST_FIX) begin
        result_q <= fix_result;
      end
    end
  end

  assign bus.busy   = (state == ST_CALC) || (state == ST_FIX);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with a result scoreboard.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int W = 32;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result = '0;
  string        cur_tag = "none";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check({cur_tag, "_done_unexpected"}, 32'(bus.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({cur_tag, "_result"}, bus.result, e);
      end
    end
  end

  function automatic logic [W-1:0] ref_model(input logic [5:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? '1 : (ovf ? a : W'($signed(a) / $signed(b)));
      OP_DIVU: return (b == 0) ? '1 : a / b;
      OP_REM:  return (b == 0) ? a  : (ovf ? '0 : W'($signed(a) % $signed(b)));
      OP_REMU: return (b == 0) ? a  : a % b;
      default: return '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic begin_req(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e, input logic push);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.operand1   = a;
    bus.operand2   = b;
    if (push) exp_q.push_back(e);
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Entered one step after the accepting edge (cycle 1); returns at the negedge
  // of the done cycle. poke_at>0 drives a stray start in that cycle only.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input int poke_at);
    int   cyc;
    int   bcnt;
    logic seen;
    cyc = 1; bcnt = 0; seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) bcnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == poke_at)          begin_req(OP_DIV, 9, 3, 3, 1'b0);
        else if (cyc == poke_at + 1) bus.start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_busy_cycles"}, bcnt, exp_busy);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e,
                        input int lat, input int bsy);
    cur_tag = tag;
    @(posedge clk);
    #1;
    begin_req(op, a, b, e, 1'b1);
    accept_edge();
    wait_done(tag, lat, bsy, 0);
    last_result = e;
  endtask

  task automatic count_idle_dones(input string tag, input int cycles);
    int nd;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check({tag, "_no_done"}, nd, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0]   ops [4];
  logic [5:0]   rop;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rspecial;

  initial begin
    ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    bus.start = 1'b0; bus.flush = 1'b0; bus.ALUControl = '0;
    bus.operand1 = '0; bus.operand2 = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op("div_20_m3",  OP_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 33);
    run_op("rem_20_m3",  OP_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         34, 33);
    run_op("rem_m20_3",  OP_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 34, 33);
    run_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34, 33);
    run_op("remu_max_2", OP_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         34, 33);
    run_op("div_7_0",    OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("remu_7_0",   OP_REMU, 32'd7,         32'd0,         32'd7,         1,  0);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("divu_big",   OP_DIVU, 32'h8000_0000, 32'd1,         32'h8000_0000, 34, 33);

    for (int i = 0; i < 6; i++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = $urandom;
      rb  = 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      rspecial = (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF);
      run_op("random", rop, ra, rb, ref_model(rop, ra, rb),
             rspecial ? 1 : 34, rspecial ? 0 : 33);
    end

    // Non-divide op code must not start anything.
    cur_tag = "bad_op";
    @(posedge clk);
    #1;
    begin_req(6'b000000, 32'd5, 32'd1, '0, 1'b0);
    accept_edge();
    @(negedge clk);
    check("bad_op_busy", 32'(bus.busy), 32'd0);
    count_idle_dones("bad_op", 4);

    // Flush in cycle 10 of a DIV.
    cur_tag = "flush";
    @(posedge clk);
    #1;
    begin_req(OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b1);
    accept_edge();
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_result_held", bus.result, last_result);
    check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
    count_idle_dones("flush", 40);

    // Reset in cycle 5 of a DIVU.
    cur_tag = "mid_reset";
    @(posedge clk);
    #1;
    begin_req(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b1);
    accept_edge();
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    check("mid_reset_done", 32'(bus.done), 32'd0);
    check("mid_reset_result", bus.result, 32'd0);
    check("mid_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_result = '0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 33);

    // Back-to-back: new REMU presented in the DONE cycle of a DIV, plus a
    // stray start during CALC that must be ignored.
    cur_tag = "b2b_div";
    @(posedge clk);
    #1;
    begin_req(OP_DIV, 32'd50, 32'd5, 32'd10, 1'b1);
    accept_edge();
    wait_done("b2b_div", 34, 33, 0);
    cur_tag = "b2b_remu";
    begin_req(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    accept_edge();
    wait_done("b2b_remu", 34, 33, 5);
    count_idle_dones("b2b_tail", 40);

    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RISC-V M-extension divide/remainder ops: DIV, DIVU, REM and REMU. The single-cycle ALU leaves these unimplemented. The block sits beside the ALU in the execute stage. It accepts an operation with a one-cycle `start`, holds the pipeline via `busy`, iterates a restoring divider one bit per cycle, and returns the sign-corrected result with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request; sampled only in IDLE or DONE.
- `ALUControl` input 6: op code.
  - 6'b010100 DIV
  - 6'b010101 DIVU
  - 6'b010110 REM
  - 6'b010111 REMU
- `operand1` input WIDTH: dividend.
- `operand2` input WIDTH: divisor.
- `flush` input 1: abort any in-flight op.
- `busy` output 1: op in flight; the pipeline stalls while high.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output WIDTH: quotient or remainder; holds until the next `done`.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Request accept:** in IDLE or DONE, `start`=1 with a valid divide op latches the op, operands and the special-case decode.
  - `start` with any other op code is ignored; the block stays put, or goes DONE→IDLE.
- **Divide by zero** (`operand2`==0): go straight to DONE.
  - DIV/DIVU return all ones.
  - REM/REMU return `operand1`.
- **Signed overflow** (DIV/REM, `operand1`==0x80000000, `operand2`==-1): go straight to DONE.
  - DIV returns 0x80000000.
  - REM returns 0.
- **Otherwise:** go to CALC with a zeroed iteration counter.
  - Signed ops first convert operands to magnitudes.
  - Record quotient sign = sign1 XOR sign2, and remainder sign = sign1.
- **CALC:** one restoring step per cycle.
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude; on no borrow, keep the difference and set quo[0].
  - Counter runs 0..WIDTH-1; the step at count WIDTH-1 moves to FIX.
- **FIX:** negate the quotient and/or remainder per the recorded signs, select quotient or remainder per op, register `result`, then go to DONE.
- **DONE:** `done`=1 for exactly one cycle.
  - Next state is CALC or DONE if a new valid `start` is present, else IDLE.
- **Flush:** `flush`=1 in any state returns to IDLE next edge.
  - No `done` is produced; `result` is unchanged.
  - `flush` wins over a simultaneous `start`.
- **Busy requests:** `start` during CALC or FIX is ignored; the requester must hold it until `busy` drops.

## Timing
- **Reset:** `rst_n`=0 at an edge gives state IDLE, `busy`=0, `done`=0, `result`=0, counter=0. Applies mid-operation too; the op is discarded.
- **Outputs:** `busy` = (state is CALC or FIX); `done` = (state is DONE). Both are decoded from registered state, with no combinational path from inputs.
- **Normal latency**, with the accepting edge as edge 0:
  - edges 1..WIDTH perform the iterations;
  - edge WIDTH+1 is FIX→DONE;
  - `done` is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles after `start`.
  - `busy` is high for WIDTH+1 cycles.
- **Special-case latency:** `done` is high in the cycle right after the accepting edge, and `busy` never rises.
- **Back-to-back:** a `start` in the DONE cycle is accepted, so throughput is one op per WIDTH+2 cycles.
- **Width rules:**
  - remainder register is WIDTH+1 bits for the borrow;
  - counter is clog2(WIDTH) bits;
  - magnitude of 0x80000000 is 0x80000000 unsigned, no overflow.

## Structure
- **Shared package:** the four divide op-code constants (shared with ALU control decode), the state enum, and the `WIDTH` default.
- **Sub-module `div_step`:** one combinational restoring iteration. It takes rem, quo and divisor, and returns next rem and quo. The FSM, sign handling and registers stay in `div_sequencer`.

## Test plan
- DIV 20 / -3 → `result`=0xFFFFFFFA, `done` exactly 34 cycles after `start`; REM 20 / -3 → 2; REM -20 / 3 → 0xFFFFFFFE.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU same operands → 1; `busy` high for 33 cycles.
- DIV 7 / 0 → 0xFFFFFFFF, and REMU 7 / 0 → 7, each with `done` 1 cycle after `start` and `busy` never high.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0; both 1-cycle latency.
- `flush` at cycle 10 of a DIV → `busy` low next cycle, no `done`, `result` unchanged. Then `rst_n`=0 at cycle 5 of a DIVU → all outputs 0. A later DIVU 100 / 7 → 14.
- `start` held with a new REMU 100 / 7 during the DONE cycle of a DIV → accepted, second `done` 34 cycles later with 2. A `start` during CALC is ignored, with no extra `done`.
